// File: rtl/stack_engine.sv
// LIFO stack with top-of-stack read, indexed peek and sticky over/underflow flags.
// Latency: push/pop/replace take effect at the sampling edge; data_out/peek follow state combinationally.
// Backpressure: none; a push while full or pop while empty is dropped and latched in a sticky error flag.
//
// Ports:
//   clk, reset         - rising-edge clock, asynchronous active-low reset
//   push, pop, data_in - push / pop / replace-top (push+pop) request and write data
//   err_clear          - clears both sticky error flags (a same-cycle new error wins)
//   peek_idx           - offset below the top to read on peek_data (0 = top)
//   data_out           - current top of stack, 0 when empty
//   peek_data/_valid   - entry at peek_idx, valid when peek_idx < count (data forced to 0 otherwise)
//   count/empty/full   - occupancy, 0..DEPTH
//   overflow_err       - sticky, set by push while full
//   underflow_err      - sticky, set by pop (or push+pop) while empty
module stack_engine #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DATA_W-1:0]          data_in,
    input  logic                       err_clear,
    input  logic [$clog2(DEPTH)-1:0]   peek_idx,
    output logic [DATA_W-1:0]          data_out,
    output logic [DATA_W-1:0]          peek_data,
    output logic                       peek_valid,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full,
    output logic                       overflow_err,
    output logic                       underflow_err
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] IDX_ONE  = AW'(1);

    // Storage is deliberately not reset; outputs are gated by count so stale
    // contents never leak out.
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [AW:0]       count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;

    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [AW-1:0]     top_addr;
    logic [AW-1:0]     peek_addr;
    logic              is_empty;
    logic              is_full;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == CNT_FULL);

    // Index arithmetic is modulo DEPTH: when full, the low AW bits of count
    // are 0 and minus one yields DEPTH-1, which is the correct top slot.
    assign top_addr  = count_q[AW-1:0] - IDX_ONE;
    assign peek_addr = top_addr - peek_idx;

    // Next-state logic. Errors never touch mem or count; set beats clear.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = '0;
        count_d = count_q;
        ovf_d   = err_clear ? 1'b0 : ovf_q;
        udf_d   = err_clear ? 1'b0 : udf_q;

        unique case ({push, pop})
            2'b10: begin
                if (is_full) begin
                    ovf_d = 1'b1;
                end else begin
                    wr_en   = 1'b1;
                    wr_addr = count_q[AW-1:0];
                    count_d = count_q + CNT_ONE;
                end
            end
            2'b01: begin
                if (is_empty) begin
                    udf_d = 1'b1;
                end else begin
                    count_d = count_q - CNT_ONE;
                end
            end
            2'b11: begin
                // Replace-top; with nothing to replace it counts as an underflow.
                if (is_empty) begin
                    udf_d = 1'b1;
                end else begin
                    wr_en   = 1'b1;
                    wr_addr = top_addr;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= data_in;
        end
    end

    assign peek_valid    = ({1'b0, peek_idx} < count_q);
    assign data_out      = is_empty   ? '0 : mem_q[top_addr];
    assign peek_data     = peek_valid ? mem_q[peek_addr] : '0;
    assign count         = count_q;
    assign empty         = is_empty;
    assign full          = is_full;
    assign overflow_err  = ovf_q;
    assign underflow_err = udf_q;

endmodule

// File: doc/stack_engine.md
STACK_ENGINE -- requirements
Module: stack_engine

Interface
REQ-001 SHALL have parameter DATA_W, default 16: width of each stack entry.
REQ-002 SHALL have parameter DEPTH, default 16: number of entries; power of two, at least 2.
REQ-003 SHALL derive local parameter AW = clog2(DEPTH), which is the index width.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 push  input  1  write request for data_in.
REQ-007 pop  input  1  remove-top request.
REQ-008 data_in  input  DATA_W  value to push or replace.
REQ-009 err_clear  input  1  clears the sticky error flags.
REQ-010 peek_idx  input  AW  offset from top: 0 is the top, 1 is the entry below it.
REQ-011 data_out  output  DATA_W  current top of stack.
REQ-012 peek_data  output  DATA_W  entry at peek_idx.
REQ-013 peek_valid  output  1  peek_idx < count.
REQ-014 count  output  AW+1  number of occupied entries, range 0..DEPTH.
REQ-015 empty  output  1  count == 0.
REQ-016 full  output  1  count == DEPTH.
REQ-017 overflow_err  output  1  sticky; set by a push attempted while full.
REQ-018 underflow_err  output  1  sticky; set by a pop attempted while empty.

Function
REQ-019 SHALL store entries in array mem[0..DEPTH-1]; mem[count-1] is the top; the array is not reset.
REQ-020 data_out SHALL be combinational: mem[count-1] when count>0, else 0.
REQ-021 peek_data SHALL be combinational: mem[count-1-peek_idx] when peek_valid, else 0.
REQ-022 push=1, pop=0, not full: next edge writes mem[count] <= data_in and count <= count+1; data_out equals data_in from the following cycle.
REQ-023 push=1, pop=0, full: no write; count unchanged; overflow_err <= 1.
REQ-024 pop=1, push=0, not empty: count <= count-1; data is not cleared; data_out shows the new top.
REQ-025 pop=1, push=0, empty: count stays 0; underflow_err <= 1.
REQ-026 push=1, pop=1, count>0 (including full): replace the top, mem[count-1] <= data_in; count unchanged; no error.
REQ-027 push=1, pop=1, empty: no write; count unchanged; underflow_err <= 1.
REQ-028 push=0, pop=0: state holds.
REQ-029 err_clear=1 SHALL clear both error flags at the next edge.
REQ-029a If a new error occurs in the same cycle as err_clear, that flag SHALL be 1, because set has priority over clear.
REQ-030 An error cycle SHALL NOT modify mem or count.
REQ-031 count SHALL never exceed DEPTH and SHALL never go below 0; there is no wrap-around.
REQ-032 Latency: a push or pop becomes visible on data_out, count, empty and full one cycle after the sampling edge; peek outputs follow count and mem combinationally.

Reset
REQ-033 reset=0 SHALL asynchronously force count=0, overflow_err=0 and underflow_err=0, independent of clk.
REQ-034 During and after reset: data_out=0, peek_data=0, peek_valid=0, empty=1, full=0.
REQ-035 Reset asserted mid-operation SHALL discard any in-flight push or pop; the first operation after reset deasserts SHALL see an empty stack.
REQ-036 mem contents after reset are don't-care and SHALL NOT be observable at the outputs.

Verification (DATA_W=16, DEPTH=4)
REQ-037 Push 0x1111, 0x2222, 0x3333, 0x4444 -> count 4, full=1, data_out=0x4444; peek_idx=3 gives peek_data=0x1111 and peek_valid=1.
REQ-038 From full, push 0x5555 -> overflow_err=1, count 4, data_out=0x4444; then err_clear -> overflow_err=0.
REQ-039 From full, push+pop with 0xAAAA -> count 4, data_out=0xAAAA, no error; then pop four times -> empty=1, data_out=0.
REQ-040 From empty, pop -> underflow_err=1, count 0; then err_clear together with another pop -> underflow_err stays 1.
REQ-041 Push 0x0001, 0x0002, then drop reset to 0 between clock edges -> count=0, empty=1 and data_out=0 immediately; release reset, then push 0x0003 -> count 1, data_out=0x0003, peek_idx=1 gives peek_valid=0.
